// File: rtl/neuron_mac_seq_if.sv
// Handshake and configuration bundle for neuron_mac_seq: vector input, result output
// and the weight/bias load port.
interface neuron_mac_seq_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N_INPUTS   = 6,
   parameter int ACC_WIDTH  = DATA_WIDTH + 6,
   parameter int IDX_W      = $clog2(N_INPUTS + 1)
);
   logic [N_INPUTS*DATA_WIDTH-1:0] x_flat;
   logic                           in_valid;
   logic                           in_ready;
   logic [1:0]                     act_mode;
   logic                           cfg_we;
   logic [IDX_W-1:0]               cfg_addr;
   logic signed [DATA_WIDTH-1:0]   cfg_data;
   logic                           cfg_ready;
   logic signed [ACC_WIDTH-1:0]    y;
   logic                           out_valid;
   logic                           out_ready;

   modport master (
      output x_flat, in_valid, act_mode, cfg_we, cfg_addr, cfg_data, out_ready,
      input  in_ready, cfg_ready, y, out_valid
   );

   modport slave (
      input  x_flat, in_valid, act_mode, cfg_we, cfg_addr, cfg_data, out_ready,
      output in_ready, cfg_ready, y, out_valid
   );
endinterface

// File: rtl/neuron_mac_seq.sv
// Fixed-point neuron: loadable weights/bias, one shared multiplier stepping through
// the fan-in, selectable activation, valid/ready on input and output.
module neuron_mac_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS  = 4,
   parameter int N_INPUTS   = 6,
   parameter int ACC_WIDTH  = DATA_WIDTH + 6,
   parameter int IDX_W      = $clog2(N_INPUTS + 1)
) (
   input logic clk,
   input logic rst,
   neuron_mac_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

   localparam int PW = 2 * DATA_WIDTH;
   localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

   state_t state_reg, state_next;

   logic signed [DATA_WIDTH-1:0] x_in      [N_INPUTS];
   logic signed [DATA_WIDTH-1:0] x_reg     [N_INPUTS];
   logic signed [DATA_WIDTH-1:0] w_reg     [N_INPUTS];
   // Weights captured at accept, so a write committed in the accept cycle
   // only affects the following vector.
   logic signed [DATA_WIDTH-1:0] w_run_reg [N_INPUTS];
   logic signed [DATA_WIDTH-1:0] bias_reg;
   logic [1:0]                   mode_reg;
   logic signed [ACC_WIDTH-1:0]  acc_reg;
   logic signed [ACC_WIDTH-1:0]  y_reg;
   logic [IDX_W-1:0]             idx_reg;

   logic                         accept;
   logic                         cfg_commit;
   logic                         last_term;
   logic [AW-1:0]                idx_trim;
   logic [AW-1:0]                cfg_idx;
   logic signed [PW-1:0]         x_ext, w_ext, prod, prod_sh;
   logic signed [ACC_WIDTH-1:0]  term;
   logic signed [ACC_WIDTH-1:0]  bias_ext;
   logic signed [ACC_WIDTH-1:0]  relu_val, act_val;
   logic                         in_ready_c, cfg_ready_c, out_valid_c;

   genvar gi;
   generate
      for (gi = 0; gi < N_INPUTS; gi++) begin : g_unpack
         assign x_in[gi] = bus.x_flat[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign accept     = (state_reg == IDLE) && bus.in_valid;
   assign cfg_commit = (state_reg == IDLE) && bus.cfg_we && (bus.cfg_addr <= IDX_W'(N_INPUTS));
   assign last_term  = (idx_reg == IDX_W'(N_INPUTS - 1));
   assign idx_trim   = idx_reg[AW-1:0];
   assign cfg_idx    = bus.cfg_addr[AW-1:0];

   assign x_ext   = {{DATA_WIDTH{x_reg[idx_trim][DATA_WIDTH-1]}}, x_reg[idx_trim]};
   assign w_ext   = {{DATA_WIDTH{w_run_reg[idx_trim][DATA_WIDTH-1]}}, w_run_reg[idx_trim]};
   assign prod    = x_ext * w_ext;
   assign prod_sh = prod >>> FRAC_BITS;

   generate
      if (ACC_WIDTH > PW) begin : g_term_ext
         assign term = {{(ACC_WIDTH-PW){prod_sh[PW-1]}}, prod_sh};
      end else begin : g_term_trunc
         assign term = prod_sh[ACC_WIDTH-1:0];
      end
   endgenerate

   // ACC_WIDTH is assumed wider than DATA_WIDTH.
   assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_reg[DATA_WIDTH-1]}}, bias_reg};

   always_comb begin
      relu_val = (mode_reg[0] && acc_reg[ACC_WIDTH-1]) ? '0 : acc_reg;
      act_val  = relu_val;
      if (mode_reg[1]) begin
         if (relu_val > SAT_MAX)      act_val = SAT_MAX;
         else if (relu_val < SAT_MIN) act_val = SAT_MIN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.in_valid) state_next = MAC;
         MAC:     if (last_term)    state_next = ACT;
         ACT:                       state_next = OUT;
         OUT:     if (bus.out_ready) state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready_c  = (state_reg == IDLE);
      cfg_ready_c = (state_reg == IDLE);
      out_valid_c = (state_reg == OUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_INPUTS; i++) begin
            x_reg[i]     <= '0;
            w_reg[i]     <= '0;
            w_run_reg[i] <= '0;
         end
         bias_reg <= '0;
         mode_reg <= '0;
         acc_reg  <= '0;
         y_reg    <= '0;
         idx_reg  <= '0;
      end else begin
         if (cfg_commit) begin
            if (bus.cfg_addr == IDX_W'(N_INPUTS)) bias_reg <= bus.cfg_data;
            else                                  w_reg[cfg_idx] <= bus.cfg_data;
         end
         case (state_reg)
            IDLE: if (accept) begin
               for (int i = 0; i < N_INPUTS; i++) begin
                  x_reg[i]     <= x_in[i];
                  w_run_reg[i] <= w_reg[i];
               end
               mode_reg <= bus.act_mode;
               acc_reg  <= bias_ext;
               idx_reg  <= '0;
            end
            MAC: begin
               acc_reg <= acc_reg + term;
               idx_reg <= idx_reg + IDX_W'(1);
            end
            ACT:     y_reg <= act_val;
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.cfg_ready = cfg_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.y         = y_reg;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench: two neurons (14- and 12-bit accumulators) share one stimulus
// stream; expected results are queued at accept and compared when out_valid rises.
module tb_neuron_mac_seq;
   localparam int DW  = 8;
   localparam int N   = 6;
   localparam int AW0 = 14;
   localparam int AW1 = 12;
   localparam int IW  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N*DW-1:0] x_flat;
   logic            in_valid, cfg_we, out_ready;
   logic [1:0]      act_mode;
   logic [IW-1:0]   cfg_addr;
   logic [DW-1:0]   cfg_data;

   neuron_mac_seq_if #(.DATA_WIDTH(DW), .N_INPUTS(N), .ACC_WIDTH(AW0), .IDX_W(IW)) bus0 ();
   neuron_mac_seq_if #(.DATA_WIDTH(DW), .N_INPUTS(N), .ACC_WIDTH(AW1), .IDX_W(IW)) bus1 ();

   neuron_mac_seq #(.DATA_WIDTH(DW), .FRAC_BITS(4), .N_INPUTS(N), .ACC_WIDTH(AW0), .IDX_W(IW))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   neuron_mac_seq #(.DATA_WIDTH(DW), .FRAC_BITS(4), .N_INPUTS(N), .ACC_WIDTH(AW1), .IDX_W(IW))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   assign bus0.x_flat = x_flat;    assign bus1.x_flat = x_flat;
   assign bus0.in_valid = in_valid; assign bus1.in_valid = in_valid;
   assign bus0.act_mode = act_mode; assign bus1.act_mode = act_mode;
   assign bus0.cfg_we = cfg_we;    assign bus1.cfg_we = cfg_we;
   assign bus0.cfg_addr = cfg_addr; assign bus1.cfg_addr = cfg_addr;
   assign bus0.cfg_data = cfg_data; assign bus1.cfg_data = cfg_data;
   assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int w_sh [N];
   int b_sh = 0;
   longint q0 [$];
   longint q1 [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic signed [63:0] got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint model(input int xs[N], input int mode, input int aw);
      longint s = b_sh;
      longint m = longint'(1) << aw;
      for (int i = 0; i < N; i++) s += (longint'(xs[i]) * longint'(w_sh[i])) >>> 4;
      s = s % m;
      if (s < 0) s += m;
      if (s >= m / 2) s -= m;
      if ((mode & 1) != 0 && s < 0) s = 0;
      if ((mode & 2) != 0) begin
         if (s > 127) s = 127;
         if (s < -128) s = -128;
      end
      return s;
   endfunction

   task automatic cfg_write(input int addr, input int data, input bit exp_ready);
      int d = data;
      @(negedge clk);
      check_val("cfg_ready", bus0.cfg_ready, longint'(exp_ready));
      cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_data = d[DW-1:0];
      @(negedge clk);
      cfg_we = 1'b0;
      if (exp_ready) begin
         if (addr < N) w_sh[addr] = data;
         else if (addr == N) b_sh = data;
      end
   endtask

   task automatic send(input int xs[N], input int mode, input bit do_cfg, input int caddr, input int cdata);
      int n = 0;
      int t;
      @(negedge clk);
      while (!bus0.in_ready && n < 20) begin @(negedge clk); n++; end
      if (!bus0.in_ready) begin
         check_val("in_ready_timeout", bus0.in_ready, 1);
         return;
      end
      for (int i = 0; i < N; i++) begin t = xs[i]; x_flat[i*DW +: DW] = t[DW-1:0]; end
      act_mode = 2'(mode);
      in_valid = 1'b1;
      q0.push_back(model(xs, mode, AW0));
      q1.push_back(model(xs, mode, AW1));
      if (do_cfg) begin
         t = cdata;
         cfg_we = 1'b1; cfg_addr = IW'(caddr); cfg_data = t[DW-1:0];
      end
      @(negedge clk);
      acc_cyc = cyc;
      in_valid = 1'b0; cfg_we = 1'b0;
      // scramble inputs after accept; the latched copy must be used
      for (int i = 0; i < N; i++) x_flat[i*DW +: DW] = DW'($urandom);
      act_mode = ~act_mode;
      if (do_cfg) begin
         if (caddr < N) w_sh[caddr] = cdata;
         else if (caddr == N) b_sh = cdata;
      end
      check_val("busy_in_ready", bus0.in_ready, 0);
   endtask

   task automatic recv(input int hold, input bit try_cfg, input int caddr, input int cdata);
      int n = 0;
      int t;
      longint e0, e1;
      while (!bus0.out_valid && n < 40) begin @(negedge clk); n++; end
      if (!bus0.out_valid) begin
         check_val("out_valid_timeout", bus0.out_valid, 1);
         return;
      end
      check_val("latency", cyc - acc_cyc, N + 1);
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check_val("y_acc14", bus0.y, e0);
      check_val("y_acc12", bus1.y, e1);
      check_val("out_valid_acc12", bus1.out_valid, 1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (try_cfg && h == 2) begin
            t = cdata;
            cfg_we = 1'b1; cfg_addr = IW'(caddr); cfg_data = t[DW-1:0];
         end
         if (h == 3) cfg_we = 1'b0;
         check_val("hold_valid", bus0.out_valid, 1);
         check_val("hold_y", bus0.y, e0);
         check_val("hold_in_ready", bus0.in_ready, 0);
         check_val("hold_cfg_ready", bus0.cfg_ready, 0);
      end
      cfg_we = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("post_valid", bus0.out_valid, 0);
      check_val("post_in_ready", bus0.in_ready, 1);
      check_val("post_y_held", bus0.y, e0);
      $display("txn: y14=%0d y12=%0d", e0, e1);
   endtask

   initial begin
      int xs [N];
      int wv [N];
      rst = 1'b1; x_flat = '0; in_valid = 1'b0; act_mode = 2'd0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b0;
      for (int i = 0; i < N; i++) w_sh[i] = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_in_ready", bus0.in_ready, 1);
      check_val("rst_cfg_ready", bus0.cfg_ready, 1);
      check_val("rst_out_valid", bus0.out_valid, 0);
      check_val("rst_y", bus0.y, 0);

      // basic weights, x = 1.0
      wv = '{-20, 1, -13, -4, 13, 2};
      for (int i = 0; i < N; i++) cfg_write(i, wv[i], 1'b1);
      cfg_write(N, 10, 1'b1);
      for (int i = 0; i < N; i++) xs[i] = 16;
      for (int m = 0; m < 3; m++) begin send(xs, m, 1'b0, 0, 0); recv(0, 1'b0, 0, 0); end
      cfg_write(N, 60, 1'b1);
      send(xs, 1, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);

      // large positive terms and saturation
      for (int i = 0; i < N; i++) cfg_write(i, 127, 1'b1);
      cfg_write(N, 0, 1'b1);
      for (int i = 0; i < N; i++) xs[i] = 127;
      send(xs, 0, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);
      send(xs, 2, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);
      for (int i = 0; i < N; i++) cfg_write(i, -128, 1'b1);
      send(xs, 2, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);
      // 6144: fits 14 bits, wraps to -2048 in 12 bits
      for (int i = 0; i < N; i++) xs[i] = -128;
      send(xs, 0, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);
      send(xs, 3, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);

      // floor behaviour of the arithmetic shift
      cfg_write(0, 1, 1'b1);
      for (int i = 1; i < N; i++) cfg_write(i, 0, 1'b1);
      xs = '{-1, 5, 5, 5, 5, 5};
      send(xs, 0, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);
      xs[0] = 1;
      send(xs, 0, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);

      // write during accept applies from the next vector; out-of-range address ignored
      xs = '{64, 0, 0, 0, 0, 0};
      send(xs, 0, 1'b1, 0, 3); recv(0, 1'b0, 0, 0);
      cfg_write(7, 99, 1'b1);
      send(xs, 0, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);

      // backpressure with a dropped config write, then readback
      send(xs, 0, 1'b0, 0, 0); recv(10, 1'b1, 0, 100);
      send(xs, 0, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);

      // random weights and vectors
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i <= N; i++) cfg_write(i, int'($urandom_range(255)) - 128, 1'b1);
         for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(255)) - 128;
         send(xs, int'($urandom_range(3)), 1'b0, 0, 0); recv(0, 1'b0, 0, 0);
      end

      // reset in the middle of MAC (idx == 3)
      send(xs, 0, 1'b0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("midrst_in_ready", bus0.in_ready, 1);
      check_val("midrst_out_valid", bus0.out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      q0.delete(); q1.delete();
      for (int i = 0; i < N; i++) w_sh[i] = 0;
      b_sh = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_val("midrst_no_valid", bus0.out_valid, 0);
      end
      for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(255)) - 128;
      send(xs, 0, 1'b0, 0, 0); recv(0, 1'b0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
Parametrised fixed-point neuron with N inputs, run-time loadable weights and bias, and selectable activation. It uses one time-multiplexed multiplier, with valid/ready handshakes on both the input and output sides. It replaces the fixed-weight, fixed-fan-in neurons in the network layers. Layer controllers chain instances through the handshakes, and a configuration port loads weights before inference.

Parameters:
DATA_WIDTH, 8, width of inputs, weights and bias (signed two's complement, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
FRAC_BITS, 4, fractional bits; each product is arithmetically shifted right by this amount
N_INPUTS, 6, fan-in; must be >= 1
ACC_WIDTH, DATA_WIDTH+6, accumulator and output width (signed)
IDX_W, clog2(N_INPUTS+1), width of the configuration address

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
x_flat  in  N_INPUTS*DATA_WIDTH  input vector; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  1  x_flat valid
in_ready  out  1  neuron can accept a vector
act_mode  in  2  activation select, sampled on input accept: 0 linear, 1 ReLU, 2 saturate, 3 ReLU+saturate
cfg_we  in  1  configuration write strobe
cfg_addr  in  IDX_W  0..N_INPUTS-1 selects a weight; N_INPUTS selects the bias
cfg_data  in  DATA_WIDTH  signed weight or bias value
cfg_ready  out  1  configuration write is accepted this cycle
y  out  ACC_WIDTH  signed result
out_valid  out  1  y valid
out_ready  in  1  downstream accepts y

Behaviour:
- Reset (async): state IDLE; in_ready=1, cfg_ready=1, out_valid=0, y=0; all weights=0, bias=0; accumulator and index cleared.
- States: IDLE, MAC, ACT, OUT.
- IDLE:
  - in_ready=1, cfg_ready=1.
  - On in_valid&&in_ready: latch x_flat and act_mode; acc <= sign-extended bias; idx <= 0; go to MAC.
- MAC:
  - One term per cycle: acc <= acc + sext((x[idx]*w[idx]) >>> FRAC_BITS).
  - The product is full 2*DATA_WIDTH signed. The shift is arithmetic, so it floors toward minus infinity. The shifted product is truncated or sign-extended to ACC_WIDTH.
  - Accumulator addition wraps modulo 2^ACC_WIDTH; there is no saturation inside MAC.
  - idx increments each cycle. On the cycle where idx==N_INPUTS-1 the last term is added and the state goes to ACT.
- ACT: computes y from acc and the latched mode in one cycle, sets out_valid=1, goes to OUT.
  - Linear: y=acc.
  - ReLU: y = (acc<0) ? 0 : acc.
  - Saturate: clamp acc to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], sign-extended to ACC_WIDTH.
  - Mode 3: ReLU first, then saturate.
- OUT:
  - y and out_valid are held stable until out_ready.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE. in_ready rises in the following cycle; there is no same-cycle turnaround.
- Latency: input accept edge at cycle 0, out_valid high after edge N_INPUTS+1. Minimum throughput is one vector per N_INPUTS+3 cycles.
- in_ready=0 in MAC, ACT and OUT. Changes on x_flat or act_mode after accept have no effect.
- Configuration:
  - A write takes effect only when cfg_we && cfg_ready (IDLE). In other states writes are silently dropped.
  - cfg_addr > N_INPUTS is ignored.
  - A write and an input accept in the same IDLE cycle: the write commits, but the vector being accepted uses the pre-write value. The write applies from the next vector on.
- y holds its last value outside OUT; it is not cleared on leaving OUT.
- Reset mid-operation: immediate return to reset values, including weights. Any vector in flight is lost, and no out_valid is produced for it.

Test Plan:
- Load W={-20,1,-13,-4,13,2}, bias=10; x all 16 (1.0), mode 0 -> y=-11, out_valid exactly 7 cycles after the accept edge.
- Same weights, bias and inputs, mode 1 -> y=0. Mode 2 -> y=-11. Set bias=60, mode 1 -> y=39.
- All W=127, x=127, bias=0: mode 0 -> y=6048 (each term 1008). Mode 2 -> y=127. All W=-128, x=127, mode 2 -> y=-128. Accumulator wrap: N=6, ACC_WIDTH=14, W=x=-128 gives terms of 1024 each, sum 6144, no wrap; force wrap with ACC_WIDTH=12 -> y=-2048.
- Floor shift: x0=-1, w0=1, other weights 0, bias 0 -> y=-1. x0=1, w0=1 -> y=0.
- Backpressure: hold out_ready=0 for 10 cycles -> y and out_valid stable, in_ready=0, cfg writes dropped (readback via a later vector shows the old weight). Release -> single handshake, in_ready=1 the next cycle.
- Assert rst during MAC (idx=3) -> out_valid stays 0, in_ready=1, and a following vector with unloaded weights gives y=0.
